// File: rtl/systolic_tile_sequencer.sv
// Sequencer for a weight-stationary systolic tile: loads weight rows, streams
// activation rows, drains the array, then clears and reports the result.
module systolic_tile_sequencer #(
  parameter int BM_NUM    = 4,
  parameter int BN_NUM    = 10,
  parameter int ACCU_NUM  = 5,
  parameter int BW_ACT    = 8,
  parameter int BW_WET    = 8,
  parameter int DRAIN_CYC = BM_NUM + 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                k_tiles,
  output logic                       busy,
  output logic                       done,
  input  logic                       wet_valid,
  output logic                       wet_ready,
  input  logic [BM_NUM*BW_WET-1:0]   wet_row,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [ACCU_NUM*BW_ACT-1:0] act_row,
  output logic                       PE_mac_enable,
  output logic                       PE_clear_acc,
  output logic                       PE_weight_partial_sel,
  output logic [ACCU_NUM*BW_ACT-1:0] PE_act_in,
  output logic [BM_NUM*BW_WET-1:0]   PE_wet_in,
  output logic                       result_valid
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WLOAD_LAST  = CNT_W'(ACCU_NUM - 1);
  localparam logic [CNT_W-1:0] STREAM_ROWS = CNT_W'(BN_NUM);
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(BN_NUM + ACCU_NUM - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLOAD  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]                 state;
  logic [CNT_W-1:0]           cnt;
  logic [15:0]                k_rem;
  logic                       zero_done;
  logic                       accepting;
  logic                       advance;
  logic [ACCU_NUM*BW_ACT-1:0] act_src;
  logic [BM_NUM*BW_WET-1:0]   wet_src;

  always_comb begin
    accepting = (state == S_STREAM) && (cnt < STREAM_ROWS);
    advance   = ((state == S_WLOAD) && wet_valid) ||
                ((state == S_STREAM) && (!accepting || act_valid)) ||
                (state == S_DRAIN);
    // Flush and drain cycles inject zero rows so nothing stale reaches the PEs
    act_src   = accepting ? act_row : '0;
    wet_src   = (state == S_WLOAD) ? wet_row : '0;
  end

  assign busy                  = (state != S_IDLE);
  assign done                  = (state == S_RESULT) || zero_done;
  assign result_valid          = (state == S_RESULT);
  assign wet_ready             = (state == S_WLOAD);
  assign act_ready             = accepting;
  assign PE_mac_enable         = advance;
  assign PE_clear_acc          = (state == S_IDLE) || (state == S_CLEAR) || (state == S_RESULT);
  assign PE_weight_partial_sel = !((state == S_STREAM) || (state == S_DRAIN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      k_rem     <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (k_tiles == 16'd0) begin
              zero_done <= 1'b1;
            end else begin
              state <= S_WLOAD;
              k_rem <= k_tiles;
              cnt   <= '0;
            end
          end
        end
        S_WLOAD: begin
          if (advance) begin
            if (cnt == WLOAD_LAST) begin
              state <= S_STREAM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (advance) begin
            if (cnt == STREAM_LAST) begin
              cnt <= '0;
              if (k_rem > 16'd1) begin
                k_rem <= k_rem - 16'd1;
                state <= S_WLOAD;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_CLEAR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CLEAR:  state <= S_RESULT;
        S_RESULT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // ---- skew stage: lane i sits i advance steps behind lane 0 ----
  for (genvar i = 0; i < ACCU_NUM; i++) begin : g_act_skew
    logic [BW_ACT-1:0] line [0:i];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int d = 0; d <= i; d++) line[d] <= '0;
      end else if (advance) begin
        line[0] <= act_src[i*BW_ACT +: BW_ACT];
        for (int d = 1; d <= i; d++) line[d] <= line[d-1];
      end
    end
    assign PE_act_in[i*BW_ACT +: BW_ACT] = line[i];
  end

  for (genvar j = 0; j < BM_NUM; j++) begin : g_wet_skew
    logic [BW_WET-1:0] line [0:j];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int d = 0; d <= j; d++) line[d] <= '0;
      end else if (advance) begin
        line[0] <= wet_src[j*BW_WET +: BW_WET];
        for (int d = 1; d <= j; d++) line[d] <= line[d-1];
      end
    end
    assign PE_wet_in[j*BW_WET +: BW_WET] = line[j];
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer: a timeline model fills an
// expectation queue, a negedge monitor pops and compares DUT outputs.
module tb_systolic_tile_sequencer;

  localparam int BM = 2, BN = 3, AC = 3, DC = 4, BA = 8, BW = 8;
  localparam int ACT_W = AC * BA;
  localparam int WET_W = BM * BW;
  localparam int MAXC  = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic [15:0] k_tiles = '0;
  logic busy, done, wet_ready, act_ready, result_valid;
  logic wet_valid = 1'b0, act_valid = 1'b0;
  logic [WET_W-1:0] wet_row = '0;
  logic [ACT_W-1:0] act_row = '0;
  logic PE_mac_enable, PE_clear_acc, PE_weight_partial_sel;
  logic [ACT_W-1:0] PE_act_in;
  logic [WET_W-1:0] PE_wet_in;

  systolic_tile_sequencer #(.BM_NUM(BM), .BN_NUM(BN), .ACCU_NUM(AC), .BW_ACT(BA),
                            .BW_WET(BW), .DRAIN_CYC(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_tiles(k_tiles),
    .busy(busy), .done(done),
    .wet_valid(wet_valid), .wet_ready(wet_ready), .wet_row(wet_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_row(act_row),
    .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
    .PE_weight_partial_sel(PE_weight_partial_sel),
    .PE_act_in(PE_act_in), .PE_wet_in(PE_wet_in), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, done, rv, wr, ar, mac, clr, sel;
    logic sel_chk;
    logic [ACT_W-1:0] act;
    logic [WET_W-1:0] wet;
  } rec_t;

  rec_t exp_q[$];
  logic [ACT_W-1:0] act_hist[$];   // row injected into the array at each advance
  logic [WET_W-1:0] wet_hist[$];
  int total = 0, bad = 0, trace_len = 0;

  bit wv[MAXC], av[MAXC], st[MAXC];
  logic [WET_W-1:0] wd[MAXC];
  logic [ACT_W-1:0] ad[MAXC];
  logic [15:0] kt[MAXC];

  function automatic rec_t mk(input logic b, dn, rv, wr, ar, mac, clr, sel, sel_chk);
    rec_t r;
    logic [ACT_W-1:0] ta;
    logic [WET_W-1:0] tw;
    r = '0;
    r.busy = b; r.done = dn; r.rv = rv; r.wr = wr; r.ar = ar;
    r.mac = mac; r.clr = clr; r.sel = sel; r.sel_chk = sel_chk;
    for (int i = 0; i < AC; i++) begin
      int idx = act_hist.size() - 1 - i;
      if (idx >= 0) begin ta = act_hist[idx]; r.act[i*BA +: BA] = ta[i*BA +: BA]; end
    end
    for (int j = 0; j < BM; j++) begin
      int idx = wet_hist.size() - 1 - j;
      if (idx >= 0) begin tw = wet_hist[idx]; r.wet[j*BW +: BW] = tw[j*BW +: BW]; end
    end
    return r;
  endfunction

  task automatic inject(input logic [ACT_W-1:0] a, input logic [WET_W-1:0] w);
    act_hist.push_back(a);
    wet_hist.push_back(w);
  endtask

  // Expected per-cycle outputs for one operation, cycle 1 = first cycle after start is sampled
  task automatic build(input int k);
    int c = 0;
    if (k == 0) begin
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1));
      trace_len = 1;
      return;
    end
    for (int t = 0; t < k; t++) begin
      int rows = 0;
      while (rows < AC) begin
        c++;
        exp_q.push_back(mk(1, 0, 0, 1, 0, wv[c], 0, 1, 1));
        if (wv[c]) begin inject('0, wd[c]); rows++; end
      end
      for (int n = 0; n < BN + AC - 1; ) begin
        bit acc, adv;
        c++;
        acc = (n < BN);
        adv = acc ? av[c] : 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, acc, adv, 0, 0, 1));
        if (adv) begin inject(acc ? ad[c] : '0, '0); n++; end
      end
    end
    for (int d = 0; d < DC; d++) begin
      c++;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      inject('0, '0);
    end
    c++; exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    c++; exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0));
    trace_len = c;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ctrl"}, 64'({busy, done, result_valid, wet_ready, act_ready,
                            PE_mac_enable, PE_clear_acc, PE_weight_partial_sel}), 64'b0000_0011);
    chk({nm, "_act"}, 64'(PE_act_in), 64'd0);
    chk({nm, "_wet"}, 64'(PE_wet_in), 64'd0);
  endtask

  task automatic fill(input bit all_valid);
    for (int c = 0; c < MAXC; c++) begin
      wv[c] = all_valid || c > 300 || ($urandom_range(0, 3) != 0);
      av[c] = all_valid || c > 300 || ($urandom_range(0, 3) != 0);
      wd[c] = WET_W'($urandom);
      ad[c] = ACT_W'($urandom);
      st[c] = ($urandom_range(0, 2) == 0);
      kt[c] = 16'($urandom_range(0, 3));
    end
  endtask

  task automatic run_op(input int k, input int exp_done, input int abort_at, input bit noise);
    int done_cyc = -1;
    build(k);
    @(posedge clk); #1;
    start = 1'b1; k_tiles = 16'(k); wet_valid = 1'b0; act_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= trace_len; c++) begin
      start = (noise && k != 0) ? st[c] : 1'b0;
      k_tiles = kt[c]; wet_valid = wv[c]; act_valid = av[c];
      wet_row = wd[c]; act_row = ad[c];
      if (c == abort_at) begin
        #1 reset_n = 1'b0;
        exp_q.delete(); act_hist.delete(); wet_hist.delete();
        #1 check_reset_vals("mid_reset");
        @(posedge clk); #1 reset_n = 1'b1;
        start = 1'b0; wet_valid = 1'b0; act_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("after_abort_idle", 64'({busy, done, result_valid}), 64'd0);
        return;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
    end
    start = 1'b0; wet_valid = 1'b0; act_valid = 1'b0;
    for (int w = 0; w < 8 && exp_q.size() != 0; w++) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (exp_done > 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done));
  endtask

  always @(negedge clk) begin
    if (reset_n && (busy || done)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output busy=%0d done=%0d rv=%0d", busy, done, result_valid);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        if ({busy, done, result_valid, wet_ready, act_ready, PE_mac_enable, PE_clear_acc} !==
              {e.busy, e.done, e.rv, e.wr, e.ar, e.mac, e.clr} ||
            (e.sel_chk && PE_weight_partial_sel !== e.sel) ||
            PE_act_in !== e.act || PE_wet_in !== e.wet) begin
          bad++;
          $display("FAIL cycle_outputs got b%0b d%0b rv%0b wr%0b ar%0b mac%0b clr%0b sel%0b act=%h wet=%h want b%0b d%0b rv%0b wr%0b ar%0b mac%0b clr%0b sel%0b act=%h wet=%h",
                   busy, done, result_valid, wet_ready, act_ready, PE_mac_enable, PE_clear_acc,
                   PE_weight_partial_sel, PE_act_in, PE_wet_in,
                   e.busy, e.done, e.rv, e.wr, e.ar, e.mac, e.clr, e.sel, e.act, e.wet);
        end
      end
    end
  end

  initial begin
    #3 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    fill(1'b1);
    ad[4] = {8'd3, 8'd2, 8'd1};
    ad[5] = {8'd6, 8'd5, 8'd4};
    ad[6] = {8'd9, 8'd8, 8'd7};
    run_op(1, 14, 0, 1'b0);

    fill(1'b1);
    av[5] = 1'b0; av[6] = 1'b0;
    run_op(1, 16, 0, 1'b0);

    fill(1'b1);
    run_op(2, 22, 0, 1'b0);

    run_op(0, 1, 0, 1'b0);

    repeat (8) begin
      fill(1'b0);
      run_op($urandom_range(1, 3), 0, 0, 1'b1);
    end

    fill(1'b1);
    run_op(1, 0, 6, 1'b0);

    fill(1'b1);
    run_op(1, 14, 0, 1'b1);
    run_op(0, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
